// File: rtl/ysyx_22040750_trap_ctrl.sv
// Trap sequencer: ecall / mret / timer interrupt -> flush, drain, CSR update, fetch redirect.
// Optional vectored-mode target computation under `YSYX_22040750_TRAP_VEC_EN.
module ysyx_22040750_trap_ctrl #(
  parameter int XLEN = 64,
  parameter int PCW  = 32
) (
  input  logic            I_sys_clk,
  input  logic            I_rst_n,
  input  logic            I_WB_valid,
  input  logic            I_WB_ecall,
  input  logic            I_WB_mret,
  input  logic [PCW-1:0]  I_WB_pc,
  input  logic [PCW-1:0]  I_WB_next_pc,
  input  logic            I_timer_intr,
  input  logic            I_mem_busy,
  input  logic [XLEN-1:0] I_csr_rd_data,
  input  logic            I_redirect_ready,
  output logic            O_flush,
  output logic            O_stall_fetch,
  output logic            O_csr_intr_wr,
  output logic            O_csr_intr_rd,
  output logic            O_csr_mret_wr,
  output logic            O_csr_mret_rd,
  output logic [PCW-1:0]  O_intr_pc,
  output logic [XLEN-1:0] O_intr_no,
  output logic            O_redirect_valid,
  output logic [PCW-1:0]  O_redirect_pc,
  output logic            O_busy
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DRAIN    = 2'd1,
    S_UPDATE   = 2'd2,
    S_REDIRECT = 2'd3
  } state_t;

  localparam logic            K_TRAP      = 1'b0;
  localparam logic            K_MRET      = 1'b1;
  localparam logic [XLEN-1:0] CAUSE_ECALL = XLEN'(11);
  localparam logic [XLEN-1:0] CAUSE_TIMER = {1'b1, {(XLEN-4){1'b0}}, 3'b111};

  state_t          r_state, w_state;
  logic            r_kind, w_kind;
  logic [PCW-1:0]  r_epc, w_epc;
  logic [XLEN-1:0] r_cause, w_cause;
  logic [PCW-1:0]  r_target, w_target;
  logic [PCW-1:0]  w_base;
  logic [PCW-1:0]  w_csr_target;
  logic            r_flush, r_intr_strb, r_mret_strb, r_redirect_valid, r_busy;
  logic            w_flush, w_intr_strb, w_mret_strb, w_redirect_valid, w_busy;
  logic            w_unused_rd;

  assign w_unused_rd = ^I_csr_rd_data[XLEN-1:PCW];
  assign w_base      = {I_csr_rd_data[PCW-1:2], 2'b00};

  // Redirect target from the pre-write mtvec/mepc read in UPDATE
  always_comb begin
    w_csr_target = w_base;
`ifdef YSYX_22040750_TRAP_VEC_EN
    if (r_kind == K_TRAP && r_cause[XLEN-1] && I_csr_rd_data[1:0] == 2'b01) begin
      w_csr_target = w_base + {{(PCW-8){1'b0}}, r_cause[5:0], 2'b00};
    end else begin
      w_csr_target = w_base;
    end
`endif
  end

  // Next-state and trap-record update
  always_comb begin
    w_state  = r_state;
    w_kind   = r_kind;
    w_epc    = r_epc;
    w_cause  = r_cause;
    w_target = r_target;
    case (r_state)
      S_IDLE: begin
        if (I_WB_valid && I_WB_ecall) begin
          w_kind  = K_TRAP;
          w_epc   = I_WB_pc;
          w_cause = CAUSE_ECALL;
          w_state = S_DRAIN;
        end else if (I_WB_valid && I_WB_mret) begin
          w_kind  = K_MRET;
          w_state = S_DRAIN;
        end else if (I_WB_valid && I_timer_intr) begin
          // Interrupt is taken after the committing instruction
          w_kind  = K_TRAP;
          w_epc   = I_WB_next_pc;
          w_cause = CAUSE_TIMER;
          w_state = S_DRAIN;
        end else begin
          w_state = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (I_mem_busy) begin
          w_state = S_DRAIN;
        end else begin
          w_state = S_UPDATE;
        end
      end
      S_UPDATE: begin
        w_target = w_csr_target;
        w_state  = S_REDIRECT;
      end
      S_REDIRECT: begin
        if (I_redirect_ready) begin
          w_state = S_IDLE;
        end else begin
          w_state = S_REDIRECT;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they can be registered
  always_comb begin
    w_flush          = (r_state == S_IDLE) && (w_state == S_DRAIN);
    w_intr_strb      = (w_state == S_UPDATE) && (r_kind == K_TRAP);
    w_mret_strb      = (w_state == S_UPDATE) && (r_kind == K_MRET);
    w_redirect_valid = (w_state == S_REDIRECT);
    w_busy           = (w_state != S_IDLE);
  end

  // State, trap record and output registers
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state          <= S_IDLE;
      r_kind           <= 1'b0;
      r_epc            <= {PCW{1'b0}};
      r_cause          <= {XLEN{1'b0}};
      r_target         <= {PCW{1'b0}};
      r_flush          <= 1'b0;
      r_intr_strb      <= 1'b0;
      r_mret_strb      <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_busy           <= 1'b0;
    end else begin
      r_state          <= w_state;
      r_kind           <= w_kind;
      r_epc            <= w_epc;
      r_cause          <= w_cause;
      r_target         <= w_target;
      r_flush          <= w_flush;
      r_intr_strb      <= w_intr_strb;
      r_mret_strb      <= w_mret_strb;
      r_redirect_valid <= w_redirect_valid;
      r_busy           <= w_busy;
    end
  end

  assign O_flush          = r_flush;
  assign O_stall_fetch    = r_busy;
  assign O_busy           = r_busy;
  assign O_csr_intr_wr    = r_intr_strb;
  assign O_csr_intr_rd    = r_intr_strb;
  assign O_csr_mret_wr    = r_mret_strb;
  assign O_csr_mret_rd    = r_mret_strb;
  assign O_intr_pc        = r_epc;
  assign O_intr_no        = r_cause;
  assign O_redirect_valid = r_redirect_valid;
  assign O_redirect_pc    = r_target;

endmodule

// File: tb/tb_ysyx_22040750_trap_ctrl.sv
// Scoreboard bench for ysyx_22040750_trap_ctrl: the driver predicts flush/update/redirect
// events with their cycles, a monitor pops and compares them as the DUT presents them.
module tb_ysyx_22040750_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid = 1'b0, wb_ecall = 1'b0, wb_mret = 1'b0, timer = 1'b0;
  logic [31:0] wb_pc = 32'd0, wb_npc = 32'd0;
  logic        mem_busy = 1'b0, rdy = 1'b0;
  logic [63:0] csr_rd;
  logic [63:0] csr_mtvec = 64'd0, csr_mepc = 64'd0;
  logic        o_flush, o_stall, o_iwr, o_ird, o_mwr, o_mrd, o_rv, o_busy;
  logic [31:0] o_ipc, o_rpc;
  logic [63:0] o_ino;

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  logic  exp_busy = 1'b0;

  typedef struct {
    int          kind;   // 0 flush, 1 csr update, 2 redirect
    int          cyc;
    logic        trap;
    logic [31:0] pc;
    logic [63:0] no;
  } ev_t;
  ev_t q[$];

  logic [31:0] m_epc = 32'd0;
  logic [63:0] m_cause = 64'd0;

  ysyx_22040750_trap_ctrl #(.XLEN(64), .PCW(32)) dut (
    .I_sys_clk(clk), .I_rst_n(rst_n),
    .I_WB_valid(wb_valid), .I_WB_ecall(wb_ecall), .I_WB_mret(wb_mret),
    .I_WB_pc(wb_pc), .I_WB_next_pc(wb_npc), .I_timer_intr(timer),
    .I_mem_busy(mem_busy), .I_csr_rd_data(csr_rd), .I_redirect_ready(rdy),
    .O_flush(o_flush), .O_stall_fetch(o_stall),
    .O_csr_intr_wr(o_iwr), .O_csr_intr_rd(o_ird),
    .O_csr_mret_wr(o_mwr), .O_csr_mret_rd(o_mrd),
    .O_intr_pc(o_ipc), .O_intr_no(o_ino),
    .O_redirect_valid(o_rv), .O_redirect_pc(o_rpc), .O_busy(o_busy)
  );

  // CSR file stand-in: read mux selected by the strobes, garbage otherwise
  assign csr_rd = o_ird ? csr_mtvec : (o_mrd ? csr_mepc : 64'hDEAD_BEEF_0BAD_F00D);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, {56'd0, o_flush, o_stall, o_iwr, o_ird, o_mwr, o_mrd, o_rv, o_busy}, 64'd0);
    chk({tag, "_pcs"}, {o_ipc, o_rpc}, 64'd0);
    chk({tag, "_no"}, o_ino, 64'd0);
  endtask

  // Monitor: compare DUT-presented events against the predicted queue
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        chk("busy", {62'd0, o_busy, o_stall}, {62'd0, exp_busy, exp_busy});
        if (o_flush) begin
          if (q.size() == 0) chk("flush_unexpected", 64'd1, 64'd0);
          else begin
            e = q.pop_front();
            chk("flush_kind", 64'(e.kind), 64'd0);
            chk("flush_cyc", 64'(cyc), 64'(e.cyc));
          end
        end
        if (o_iwr | o_ird | o_mwr | o_mrd) begin
          if (q.size() == 0) chk("update_unexpected", 64'd1, 64'd0);
          else begin
            e = q.pop_front();
            chk("update_kind", 64'(e.kind), 64'd1);
            chk("update_cyc", 64'(cyc), 64'(e.cyc));
            chk("update_strobes", {60'd0, o_iwr, o_ird, o_mwr, o_mrd},
                e.trap ? 64'hC : 64'h3);
            chk("intr_pc", {32'd0, o_ipc}, {32'd0, e.pc});
            chk("intr_no", o_ino, e.no);
          end
        end
        if (o_rv) begin
          if (q.size() == 0) chk("redirect_unexpected", 64'd1, 64'd0);
          else begin
            e = q[0];
            chk("redirect_kind", 64'(e.kind), 64'd2);
            chk("redirect_pc", {32'd0, o_rpc}, {32'd0, e.pc});
            if (rdy) begin
              chk("redirect_cyc", 64'(cyc), 64'(e.cyc));
              void'(q.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic do_reset_mid();
    #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    q.delete();
    m_epc    = 32'd0;
    m_cause  = 64'd0;
    exp_busy = 1'b0;
    @(negedge clk);
    #4;
    rst_n = 1'b1;
  endtask

  // One commit plus its whole sequence; ra=1 resets in DRAIN, ra=2 in REDIRECT
  task automatic do_trial(input logic v, input logic e, input logic m, input logic t,
                          input logic [31:0] pc, input logic [31:0] npc,
                          input logic [63:0] tvec, input logic [63:0] mepc,
                          input int nb, input int nr, input int ra);
    logic        fire, trap;
    logic [31:0] tgt;
    int          t0, n;
    ev_t         ev;
    @(negedge clk);
    t0 = cyc;
    wb_valid = v; wb_ecall = e; wb_mret = m; timer = t;
    wb_pc = pc; wb_npc = npc;
    csr_mtvec = tvec; csr_mepc = mepc;
    mem_busy = 1'($urandom_range(0, 1));
    rdy = 1'($urandom_range(0, 1));
    exp_busy = 1'b0;
    fire = v && (e || m || t);
    trap = 1'b0;
    if (fire) begin
      if (e) begin
        trap = 1'b1; m_epc = pc; m_cause = 64'd11;
      end else if (!m) begin
        trap = 1'b1; m_epc = npc; m_cause = 64'h8000_0000_0000_0007;
      end
      if (trap) begin
        tgt = tvec[31:0] & 32'hFFFF_FFFC;
`ifdef YSYX_22040750_TRAP_VEC_EN
        if (m_cause[63] && tvec[1:0] == 2'b01) tgt = tgt + 32'd4 * {26'd0, m_cause[5:0]};
`endif
      end else begin
        tgt = mepc[31:0] & 32'hFFFF_FFFC;
      end
      ev = '{kind: 0, cyc: t0 + 1, trap: trap, pc: 32'd0, no: 64'd0};
      q.push_back(ev);
      ev = '{kind: 1, cyc: t0 + 2 + nb, trap: trap, pc: m_epc, no: m_cause};
      q.push_back(ev);
      ev = '{kind: 2, cyc: t0 + 3 + nb + nr, trap: trap, pc: tgt, no: 64'd0};
      q.push_back(ev);
    end
    n = fire ? nb + nr + 3 : 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      wb_valid = 1'($urandom_range(0, 1));
      wb_ecall = 1'($urandom_range(0, 1));
      wb_mret  = 1'($urandom_range(0, 1));
      timer    = 1'($urandom_range(0, 1));
      wb_pc    = $urandom;
      wb_npc   = $urandom;
      exp_busy = 1'b1;
      if (k <= nb) mem_busy = 1'b1;
      else if (k == nb + 1) mem_busy = 1'b0;
      else mem_busy = 1'($urandom_range(0, 1));
      if (k >= nb + 3) rdy = (k >= nb + 3 + nr);
      else rdy = 1'($urandom_range(0, 1));
      if ((ra == 1 && k == 1) || (ra == 2 && k == nb + 3)) begin
        do_reset_mid();
        return;
      end
    end
  endtask

  initial begin
    logic [63:0] tv;
    #2;
    chk_all_zero("reset");
    @(negedge clk);
    #4;
    rst_n = 1'b1;
    wb_valid = 1'b0;
    do_trial(1'b1, 1'b1, 1'b0, 1'b0, 32'h8000_0100, 32'h8000_0104,
             64'h8000_1000, 64'd0, 0, 0, 0);
    do_trial(1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0200, 32'h8000_0204,
             64'h8000_1000, 64'd0, 0, 0, 0);
    do_trial(1'b1, 1'b1, 1'b0, 1'b1, 32'h8000_0300, 32'h8000_0304,
             64'h8000_1000, 64'd0, 3, 0, 0);
    do_trial(1'b1, 1'b0, 1'b1, 1'b0, 32'h8000_0400, 32'h8000_0404,
             64'h8000_1000, 64'h8000_0104, 0, 2, 0);
    do_trial(1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0500, 32'h8000_0504,
             64'h8000_1001, 64'd0, 1, 1, 0);
    do_trial(1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_0600, 32'h8000_0604,
             64'h8000_1000, 64'd0, 0, 0, 0);
    do_trial(1'b1, 1'b1, 1'b0, 1'b0, 32'h8000_0700, 32'h8000_0704,
             64'h8000_1000, 64'd0, 2, 0, 1);
    do_trial(1'b1, 1'b1, 1'b0, 1'b0, 32'h8000_0800, 32'h8000_0804,
             64'h8000_2000, 64'd0, 1, 3, 2);
    do_trial(1'b1, 1'b1, 1'b0, 1'b0, 32'h8000_0900, 32'h8000_0904,
             64'h8000_3000, 64'd0, 0, 0, 0);
    for (int i = 0; i < 80; i++) begin
      tv = {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) tv[1:0] = 2'b01;
      do_trial(1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
               {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, $urandom, tv,
               {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 3), 0);
    end
    @(negedge clk);
    wb_valid = 1'b0;
    exp_busy = 1'b0;
    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
